// File: rtl/sdram_port_arbiter.sv
// CPU/video arbiter for the single SDRAM command port.
// Video has priority, and CPU starvation is bounded by VID_STARVE_MAX.
module sdram_port_arbiter #(
   parameter int ADDR_W         = 25,
   parameter int VID_STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              COCO_RESET_N,
   input  logic              cpu_req,
   input  logic              cpu_rnw,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_din,
   output logic              cpu_ack,
   output logic              cpu_ready,
   output logic [15:0]       cpu_dout,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_ack,
   output logic              vid_ready,
   output logic [15:0]       vid_dout,
   output logic              mem_req,
   output logic              mem_rnw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_din,
   input  logic              mem_ack,
   input  logic              mem_ready,
   input  logic [15:0]       mem_dout,
   input  logic              mem_busy,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_RD,
      DONE
   } state_t;

   localparam logic [3:0] STARVE_LIM = 4'(VID_STARVE_MAX);

   state_t     state;
   state_t     state_n;
   logic [3:0] starve_cnt;
   logic [3:0] starve_n;
   logic       owner_vid;
   logic       grant;
   logic       grant_vid;
   logic       cap;
   logic       cpu_wins_tie;
   logic       to_done;

   assign cpu_wins_tie = (starve_cnt >= STARVE_LIM);
   assign to_done      = (state_n == DONE);

   always_comb begin
      state_n   = state;
      starve_n  = starve_cnt;
      grant     = 1'b0;
      grant_vid = 1'b0;
      cap       = 1'b0;
      unique case (state)
         IDLE: begin
            if (!cpu_req)
               starve_n = '0;
            if (!mem_busy && (cpu_req || vid_req)) begin
               grant   = 1'b1;
               state_n = ISSUE;
               unique case (1'b1)
                  (vid_req && !cpu_req): grant_vid = 1'b1;
                  (cpu_req && !vid_req): grant_vid = 1'b0;
                  default:               grant_vid = !cpu_wins_tie;
               endcase
               if (!grant_vid)
                  starve_n = '0;
               else if (cpu_req && !cpu_wins_tie)
                  starve_n = starve_cnt + 4'd1;
            end
         end
         ISSUE: begin
            if (mem_ack) begin
               if (!mem_rnw) begin
                  state_n = DONE;
               end else if (mem_ready) begin
                  cap     = 1'b1;
                  state_n = DONE;
               end else begin
                  state_n = WAIT_RD;
               end
            end
         end
         WAIT_RD: begin
            if (mem_ready) begin
               cap     = 1'b1;
               state_n = DONE;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge COCO_RESET_N) begin
      if (!COCO_RESET_N) begin
         state      <= IDLE;
         starve_cnt <= '0;
      end else begin
         state      <= state_n;
         starve_cnt <= starve_n;
      end
   end

   // Command registers are loaded only at grant so they stay stable
   // for the whole time mem_req is held.
   always_ff @(posedge clk or negedge COCO_RESET_N) begin
      if (!COCO_RESET_N) begin
         owner_vid <= 1'b0;
         mem_rnw   <= 1'b0;
         mem_addr  <= '0;
         mem_din   <= '0;
      end else if (grant) begin
         owner_vid <= grant_vid;
         mem_rnw   <= grant_vid ? 1'b1 : cpu_rnw;
         mem_addr  <= grant_vid ? vid_addr : cpu_addr;
         mem_din   <= grant_vid ? 8'h00 : cpu_din;
      end
   end

   always_ff @(posedge clk or negedge COCO_RESET_N) begin
      if (!COCO_RESET_N) begin
         mem_req   <= 1'b0;
         busy      <= 1'b0;
         cpu_ack   <= 1'b0;
         cpu_ready <= 1'b0;
         vid_ack   <= 1'b0;
         vid_ready <= 1'b0;
      end else begin
         mem_req   <= (state_n == ISSUE);
         busy      <= (state_n != IDLE);
         cpu_ack   <= to_done && !owner_vid;
         cpu_ready <= to_done && !owner_vid && mem_rnw;
         vid_ack   <= to_done && owner_vid;
         vid_ready <= to_done && owner_vid;
      end
   end

   // Read data lands directly in the owner's output register, so it is
   // valid in the DONE cycle alongside the ack pulse.
   always_ff @(posedge clk or negedge COCO_RESET_N) begin
      if (!COCO_RESET_N) begin
         cpu_dout <= '0;
         vid_dout <= '0;
      end else if (cap) begin
         if (owner_vid)
            vid_dout <= mem_dout;
         else
            cpu_dout <= mem_dout;
      end
   end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Shares the single SDRAM command port between the CPU requester and the video fetch requester in the CoCo3 core. It sits between `coco3fpga` and the SDRAM controller, in the 114 MHz SDRAM clock domain. It serialises requests one at a time, gives video priority with a bounded CPU starvation limit, holds the command stable until the controller accepts it, and routes read data back to the requester that issued the command.

## Interface
- `ADDR_W`, 25: SDRAM byte address width.
- `VID_STARVE_MAX`, 4: maximum consecutive video grants while `cpu_req` is pending; range 1..15.
- `clk` in 1: SDRAM clock (CLK_114). All logic is on the rising edge.
- `COCO_RESET_N` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: level request, held until `cpu_ack`.
- `cpu_rnw` in 1: 1 = read, 0 = write.
- `cpu_addr` in ADDR_W: CPU byte address.
- `cpu_din` in 8: CPU write data.
- `cpu_ack` out 1: one-cycle pulse marking CPU transaction complete.
- `cpu_ready` out 1: one-cycle pulse, coincident with `cpu_ack`, on reads only.
- `cpu_dout` out 16: CPU read data; holds its value until the next CPU read completes.
- `vid_req` in 1: video read request (video is always a read), level held until `vid_ack`.
- `vid_addr` in ADDR_W: video address.
- `vid_ack` out 1: one-cycle pulse marking video read complete.
- `vid_ready` out 1: one-cycle pulse, coincident with `vid_ack`.
- `vid_dout` out 16: video read data; holds its value until the next video read completes.
- `mem_req` out 1: command request to the controller.
- `mem_rnw` out 1: command direction.
- `mem_addr` out ADDR_W: command address.
- `mem_din` out 8: command write data.
- `mem_ack` in 1: one-cycle pulse, command accepted.
- `mem_ready` in 1: one-cycle pulse, read data valid.
- `mem_dout` in 16: read data.
- `mem_busy` in 1: controller in init or refresh; no new grant is issued while this is high.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD, DONE.
- **IDLE:**
  - If `mem_busy`=0 and any request is pending, arbitrate, latch the winner's rnw/addr/din into the command registers, and go to ISSUE.
  - Otherwise stay in IDLE.
- **Arbitration:**
  - Only one requester pending: that requester wins.
  - Both pending: video wins unless `starve_cnt` == VID_STARVE_MAX, in which case CPU wins.
- **`starve_cnt` (4 bits):**
  - Increments on a video grant while `cpu_req`=1, saturating at VID_STARVE_MAX.
  - Clears on any CPU grant, or on any IDLE cycle with `cpu_req`=0.
- **ISSUE:**
  - `mem_req`=1, and `mem_rnw`/`mem_addr`/`mem_din` stay stable.
  - On `mem_ack` for a write: go to DONE.
  - On `mem_ack` for a read:
    - If `mem_ready` is high in the same cycle, capture `mem_dout` and go to DONE.
    - Otherwise go to WAIT_RD.
  - `mem_ready` without `mem_ack` in ISSUE is ignored.
  - `mem_busy` rising while in ISSUE has no effect; `mem_req` stays held.
- **WAIT_RD:**
  - `mem_req`=0.
  - On `mem_ready`, capture `mem_dout` into an internal register and go to DONE.
- **DONE:** one cycle.
  - Pulse `<owner>_ack`.
  - For reads, also pulse `<owner>_ready` and update `<owner>_dout` with the captured data.
  - Next state is IDLE.
- Requesters deassert `req` on the edge that samples `ack`. IDLE therefore never re-serves a completed request.
- `cpu_dout` and `vid_dout` are not affected by the other requester's transactions.
- **Reset** (asynchronous, at any time, including mid-transaction):
  - State goes to IDLE.
  - `starve_cnt`=0.
  - All outputs go to 0: `mem_req`, `mem_rnw`, `mem_addr`, `mem_din`, `cpu_ack`, `cpu_ready`, `vid_ack`, `vid_ready`, `cpu_dout`, `vid_dout`, `busy`.
  - An in-flight transaction is dropped without an ack.

## Timing
- Request seen in IDLE at cycle 0 → `mem_req`=1 at cycle 1.
- Write: `mem_ack` at cycle k → `cpu_ack` at cycle k+1 → IDLE at k+2.
- Read: `mem_ready` at cycle m (m ≥ k) → `*_ack`/`*_ready`/`*_dout` valid at cycle m+1.
- Minimum transaction spacing: 4 cycles (IDLE, ISSUE, DONE, IDLE) for writes and same-cycle ack/ready reads; 5 cycles for reads that pass through WAIT_RD.
- `busy` is registered and equals (state != IDLE).
- At most one command is outstanding; no pipelining.

## Test plan
- **CPU write alone:** `cpu_req`=1, rnw=0, addr=0x000123, din=0xA5; controller acks 3 cycles after `mem_req` → `mem_addr`=0x000123 and `mem_din`=0xA5 stable from `mem_req` rise until `mem_ack`; one `cpu_ack` pulse; `cpu_ready` stays 0.
- **Video read with split ack/ready:** `mem_ack` at cycle 2, `mem_ready` with `mem_dout`=0xBEEF at cycle 6 → `vid_ack`=`vid_ready`=1 at cycle 7 with `vid_dout`=0xBEEF; `cpu_dout` unchanged.
- **Starvation bound:** `cpu_req` (read) and `vid_req` held continuously, VID_STARVE_MAX=4 → grant order V,V,V,V,C,V,V,V,V,C…; `starve_cnt` never exceeds 4.
- **Busy gating:** `mem_busy`=1 for 20 cycles while `cpu_req`=1 → `mem_req` stays 0 throughout; grant occurs on the first IDLE cycle after `mem_busy` falls.
- **Same-cycle ack and ready:** controller drives `mem_ack` and `mem_ready` together → FSM skips WAIT_RD; `cpu_ready` appears one cycle later.
- **Reset mid-read:** `COCO_RESET_N` pulsed low in WAIT_RD → all outputs 0 immediately; no ack pulse; after release, a pending `vid_req` is granted normally.
